// File: rtl/alu_exec_unit.sv
// RV32I ALU execute unit with valid/ready handshake and a registered result.
// Define ALU_MULDIV_EN to add the iterative RV32M multiply/divide engine.
module alu_exec_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      op,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [1:0]      ALUOp,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_nx;
    logic               accept;
    logic               is_md;
    logic               md_last;
    logic [XLEN-1:0]    alu_res;
    logic [XLEN-1:0]    sra_res;
    logic [SHAMT_W-1:0] sh;
    logic               unused;

    // Only op[5] and funct7[5]/full funct7 participate in decode.
    assign unused = ^{op[6], op[4:0], funct7[6], funct7[4:0]};

    assign in_ready = !reset && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    assign accept   = in_valid && in_ready;

    // Base RV32I operation, evaluated on the presented operands.
    always_comb begin
        sh      = b[SHAMT_W-1:0];
        sra_res = $signed(a) >>> sh;
        alu_res = a + b;
        case (ALUOp)
            2'b01: alu_res = a - b;
            2'b10: begin
                case (funct3)
                    3'b000:  alu_res = (op[5] && funct7[5]) ? a - b : a + b;
                    3'b001:  alu_res = a << sh;
                    3'b010:  alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
                    3'b011:  alu_res = {{(XLEN-1){1'b0}}, a < b};
                    3'b100:  alu_res = a ^ b;
                    3'b101:  alu_res = funct7[5] ? sra_res : a >> sh;
                    3'b110:  alu_res = a | b;
                    default: alu_res = a & b;
                endcase
            end
            default: alu_res = a + b;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic [SHAMT_W-1:0] md_cnt;
    logic [XLEN-1:0]    md_hi;
    logic [XLEN-1:0]    md_lo;
    logic [XLEN-1:0]    md_den;
    logic [XLEN-1:0]    md_a;
    logic [2:0]         md_f3;
    logic               md_neg_q;
    logic               md_neg_r;
    logic               md_div0;
    logic [XLEN-1:0]    hi_nx;
    logic [XLEN-1:0]    lo_nx;
    logic [XLEN:0]      sum;
    logic [XLEN:0]      shifted;
    logic [XLEN:0]      trial;
    logic [2*XLEN-1:0]  prod;
    logic [XLEN-1:0]    md_res;
    logic               sa;
    logic               sb;
    logic [XLEN-1:0]    abs_a;
    logic [XLEN-1:0]    abs_b;

    assign is_md   = (ALUOp == 2'b10) && op[5] && (funct7 == 7'b0000001);
    assign md_last = (md_cnt == SHAMT_W'(XLEN - 1));

    // Operand signs: MULH/MULHSU/DIV/REM treat a as signed; MULH/DIV/REM treat b as signed.
    always_comb begin
        sa    = a[XLEN-1] && ((funct3 == 3'b001) || (funct3 == 3'b010) ||
                              (funct3 == 3'b100) || (funct3 == 3'b110));
        sb    = b[XLEN-1] && ((funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110));
        abs_a = sa ? -a : a;
        abs_b = sb ? -b : b;
    end

    // One shift-add or restoring-divide step on magnitudes, plus final sign fix-up.
    always_comb begin
        sum     = {1'b0, md_hi} + (md_lo[0] ? {1'b0, md_den} : '0);
        shifted = {md_hi, md_lo[XLEN-1]};
        trial   = shifted - {1'b0, md_den};
        if (!md_f3[2]) begin
            {hi_nx, lo_nx} = {sum, md_lo[XLEN-1:1]};
        end else begin
            hi_nx = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
            lo_nx = {md_lo[XLEN-2:0], !trial[XLEN]};
        end
        prod = md_neg_q ? -{hi_nx, lo_nx} : {hi_nx, lo_nx};
        case (md_f3)
            3'b000:        md_res = prod[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:        md_res = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101: md_res = md_div0 ? '1 : (md_neg_q ? -lo_nx : lo_nx);
            default:       md_res = md_div0 ? md_a : (md_neg_r ? -hi_nx : hi_nx);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            md_cnt   <= '0;
            md_hi    <= '0;
            md_lo    <= '0;
            md_den   <= '0;
            md_a     <= '0;
            md_f3    <= '0;
            md_neg_q <= 1'b0;
            md_neg_r <= 1'b0;
            md_div0  <= 1'b0;
        end else if (accept && is_md) begin
            md_cnt   <= '0;
            md_hi    <= '0;
            md_lo    <= abs_a;
            md_den   <= abs_b;
            md_a     <= a;
            md_f3    <= funct3;
            md_neg_q <= sa ^ sb;
            md_neg_r <= sa;
            md_div0  <= (b == '0);
        end else if (state == S_RUN) begin
            md_cnt <= md_cnt + SHAMT_W'(1);
            md_hi  <= hi_nx;
            md_lo  <= lo_nx;
        end
    end
`else
    assign is_md   = 1'b0;
    assign md_last = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = is_md ? S_RUN : S_DONE;
            S_RUN:  if (md_last) state_nx = S_DONE;
            S_DONE: begin
                if (accept)         state_nx = is_md ? S_RUN : S_DONE;
                else if (out_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Registered outputs track the next state; result only moves on completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
        end else begin
            out_valid <= (state_nx == S_DONE);
            busy      <= (state_nx == S_RUN);
            if (accept && !is_md) begin
                result <= alu_res;
                zero   <= (alu_res == '0);
            end
`ifdef ALU_MULDIV_EN
            else if ((state == S_RUN) && md_last) begin
                result <= md_res;
                zero   <= (md_res == '0);
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (XLEN=32).
module tb_alu_exec_unit;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] F7_0 = 7'b0000000;
    localparam logic [6:0] F7_A = 7'b0100000;
    localparam logic [6:0] F7_M = 7'b0000001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  op = '0;
    logic [2:0]  funct3 = '0;
    logic [6:0]  funct7 = '0;
    logic [1:0]  alu_op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .funct3    (funct3),
        .funct7    (funct7),
        .ALUOp     (alu_op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ao, input logic [6:0] o, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] av, input logic [31:0] bv);
        alu_op   = ao;
        op       = o;
        funct3   = f3;
        funct7   = f7;
        a        = av;
        b        = bv;
        in_valid = 1'b1;
    endtask

    // Single-cycle op with out_ready high: result is expected right after the accept edge.
    task automatic issue(input string tag, input logic [1:0] ao, input logic [6:0] o,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] av, input logic [31:0] bv, input logic [31:0] exp);
        drive(ao, o, f3, f7, av, bv);
        out_ready = 1'b1;
        tick();
        chk({tag, ".res"}, 64'(result), 64'(exp));
        chk({tag, ".zero"}, 64'(zero), 64'(exp == 32'd0));
        chk({tag, ".vld"}, 64'(out_valid), 64'd1);
    endtask

    task automatic go_idle();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
    endtask

`ifdef ALU_MULDIV_EN
    // Multi-cycle op: expect exactly 32 busy cycles, then the result.
    task automatic issue_md(input string tag, input logic [2:0] f3,
                            input logic [31:0] av, input logic [31:0] bv, input logic [31:0] exp);
        int n;
        int nb;
        n  = 0;
        nb = 0;
        drive(2'b10, OP_R, f3, F7_M, av, bv);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, ".rdy_run"}, 64'(in_ready), 64'd0);
        while (!out_valid && n < 100) begin
            if (busy) nb++;
            tick();
            n++;
        end
        chk({tag, ".lat"}, 64'(n), 64'd32);
        chk({tag, ".busy"}, 64'(nb), 64'd32);
        chk({tag, ".res"}, 64'(result), 64'(exp));
        go_idle();
    endtask
`endif

    initial begin
        // Reset with an operation presented
        out_ready = 1'b1;
        drive(2'b10, OP_R, 3'b000, F7_A, 32'd5, 32'd7);
        tick();
        tick();
        chk("rst.in_ready", 64'(in_ready), 64'd0);
        chk("rst.out_valid", 64'(out_valid), 64'd0);
        chk("rst.result", 64'(result), 64'd0);
        chk("rst.zero", 64'(zero), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);
        reset = 1'b0;
        #1;
        chk("post_rst.in_ready", 64'(in_ready), 64'd1);
        tick();
        chk("sub57.res", 64'(result), 64'hFFFF_FFFE);
        chk("sub57.zero", 64'(zero), 64'd0);
        chk("sub57.vld", 64'(out_valid), 64'd1);

        // Back-to-back
        issue("xor", 2'b10, OP_R, 3'b100, F7_0, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0);
        issue("slt", 2'b10, OP_R, 3'b010, F7_0, 32'hFFFF_FFFF, 32'd1, 32'd1);
        go_idle();
        chk("idle.vld", 64'(out_valid), 64'd0);
        chk("idle.busy", 64'(busy), 64'd0);

        // Stall: a pending op must wait until out_ready
        drive(2'b10, OP_R, 3'b101, F7_A, 32'h8000_0000, 32'h24);
        out_ready = 1'b0;
        tick();
        drive(2'b00, OP_R, 3'b000, F7_0, 32'd1, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("stall.rdy", 64'(in_ready), 64'd0);
            chk("stall.vld", 64'(out_valid), 64'd1);
            chk("stall.res", 64'(result), 64'hF800_0000);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("unstall.rdy", 64'(in_ready), 64'd1);
        tick();
        chk("after_stall.res", 64'(result), 64'd2);
        go_idle();

        // Main-decoder classes and remaining funct3 ops
        issue("aluop01", 2'b01, OP_R, 3'b111, F7_0, 32'd9, 32'd9, 32'd0);
        issue("aluop11", 2'b11, OP_R, 3'b111, F7_0, 32'd2, 32'd3, 32'd5);
        issue("addi_f7", 2'b10, OP_I, 3'b000, F7_A, 32'd5, 32'd7, 32'd12);
        issue("sll", 2'b10, OP_R, 3'b001, F7_0, 32'd1, 32'h21, 32'd2);
        issue("slt_neg", 2'b10, OP_R, 3'b010, F7_0, 32'd1, 32'hFFFF_FFFF, 32'd0);
        issue("sltu", 2'b10, OP_R, 3'b011, F7_0, 32'd1, 32'hFFFF_FFFF, 32'd1);
        issue("srl", 2'b10, OP_R, 3'b101, F7_0, 32'h8000_0000, 32'd4, 32'h0800_0000);
        issue("or", 2'b10, OP_R, 3'b110, F7_0, 32'h0000_00F0, 32'h0000_0F0F, 32'h0000_0FFF);
        issue("and", 2'b10, OP_R, 3'b111, F7_0, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00);
        issue("add_wrap", 2'b00, OP_R, 3'b000, F7_0, 32'hFFFF_FFFF, 32'd2, 32'd1);
`ifndef ALU_MULDIV_EN
        issue("f7m_base", 2'b10, OP_R, 3'b000, F7_M, 32'd3, 32'd4, 32'd7);
        chk("f7m_base.busy", 64'(busy), 64'd0);
`endif
        go_idle();

`ifdef ALU_MULDIV_EN
        issue_md("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        issue_md("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        issue_md("remu_z", 3'b111, 32'd7, 32'd0, 32'd7);
        issue_md("div_z", 3'b100, 32'd7, 32'd0, 32'hFFFF_FFFF);
        issue_md("mul", 3'b000, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1);
        issue_md("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);

        // Reset mid-RUN abandons the division
        drive(2'b10, OP_R, 3'b100, F7_M, 32'd100, 32'd7);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid || busy) begin
                chk("abort.vld", 64'(out_valid), 64'd0);
                chk("abort.busy", 64'(busy), 64'd0);
                break;
            end
            tick();
        end
        chk("abort.final_vld", 64'(out_valid), 64'd0);
        issue("abort.add", 2'b00, OP_R, 3'b000, F7_0, 32'd1, 32'd1, 32'd2);
        go_idle();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
